// File: rtl/arb8way16_pkg.sv
// Shared definitions for the 8-way round-robin bus arbiter:
// state encoding, word width, burst-length limits and a one-hot helper.
package arb8way16_pkg;

  localparam int WORD_W        = 16;
  localparam int NREQ          = 8;
  localparam int MAX_BURST_MIN = 1;
  localparam int MAX_BURST_MAX = 16;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [NREQ-1:0] onehot8(input logic [2:0] i);
    return 8'b1 << i;
  endfunction

endpackage

// File: rtl/arb8way16_mux.sv
// 8-to-1 mux of 16-bit words.
// Ports: d (8 packed words, word i at d[16*i+15:16*i]), sel, out.
module mux8way16 (
  input  logic [127:0] d,
  input  logic [2:0]   sel,
  output logic [15:0]  out
);

  assign out = d[{sel, 4'b0000} +: 16];

endmodule

// File: rtl/arb8way16_rr_pick8.sv
// Rotating-priority search over 8 request bits.
// Ports: req, start (first index examined), found, idx (winner).
module rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] start,
  output logic       found,
  output logic [2:0] idx
);

  logic [2:0] j;

  // Scan from the farthest offset down so the nearest
  // set bit to start is the last (and winning) assignment.
  always_comb begin
    found = 1'b0;
    idx   = 3'd0;
    j     = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      j = start + 3'(k);
      if (req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/arb8way16.sv
// Round-robin arbiter sharing one 16-bit channel among 8 requesters.
// Ports: clk, reset (sync, active-high), req, data_in, out_ready,
//        out, out_valid, grant (one-hot), sel, busy.
module arb8way16
  import arb8way16_pkg::*;
#(
  parameter int MAX_BURST = 4  // legal 1..16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WORD_W-1:0] data_in,
  input  logic                   out_ready,
  output logic [WORD_W-1:0]      out,
  output logic                   out_valid,
  output logic [NREQ-1:0]        grant,
  output logic [2:0]             sel,
  output logic                   busy
);

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [2:0]      sel_q, sel_d;
  logic [2:0]      last_q, last_d;
  logic [3:0]      cnt_q, cnt_d;

  logic       found;
  logic [2:0] idx;
  logic [2:0] start;
  logic       accept;
  logic       rel;

  // One search serves both cases: from IDLE it resumes after
  // the last winner, on release it resumes after the holder.
  assign start = ((state_q == ARB_IDLE) ? last_q : sel_q) + 3'd1;

  rr_pick8 u_pick (
    .req   (req),
    .start (start),
    .found (found),
    .idx   (idx)
  );

  mux8way16 u_mux (
    .d   (data_in),
    .sel (sel_q),
    .out (out)
  );

  assign busy      = (state_q == ARB_GRANT);
  assign out_valid = busy & req[sel_q];
  assign accept    = out_valid & out_ready;
  assign rel       = busy &
                     (~req[sel_q] |
                      (accept & (cnt_q == LAST_BEAT)));
  assign grant     = grant_q;
  assign sel       = sel_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (found) begin
          state_d = ARB_GRANT;
          grant_d = onehot8(idx);
          sel_d   = idx;
          last_d  = idx;
          cnt_d   = 4'd0;
        end
      end
      ARB_GRANT: begin
        if (rel) begin
          cnt_d = 4'd0;
          if (found) begin
            grant_d = onehot8(idx);
            sel_d   = idx;
            last_d  = idx;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
        end else if (accept) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      sel_q   <= 3'd0;
      last_q  <= 3'd7;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
